// File: rtl/sw_seq_data_processor.sv
// Smith-Waterman sequence data processor: holds query S and target T symbols,
// streams them to the PE-array controller, and keeps a column buffer of the
// last PE's {t,v,f} results so later passes over T read the previous pass.
module sw_seq_data_processor #(
  parameter int VEF_BIT = 16,
  parameter int S_LOG   = 8,
  parameter int T_LOG   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_s_wr,
  input  logic [S_LOG-1:0]   i_s_addr,
  input  logic [1:0]         i_s_sym,
  input  logic               i_t_wr,
  input  logic [T_LOG-1:0]   i_t_addr,
  input  logic [1:0]         i_t_sym,
  input  logic [S_LOG:0]     i_s_len,
  input  logic [T_LOG:0]     i_t_len,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_ovf,
  output logic               o_data_valid,
  input  logic               i_update_s_w,
  output logic [1:0]         o_s,
  output logic               o_s_last,
  input  logic               i_update_t_w,
  output logic [1:0]         o_t,
  output logic [VEF_BIT-1:0] o_v,
  output logic [VEF_BIT-1:0] o_f,
  output logic               o_t_last,
  input  logic               i_t_valid,
  input  logic [1:0]         i_t,
  input  logic [VEF_BIT-1:0] i_v,
  input  logic [VEF_BIT-1:0] i_f
);

  localparam int S_DEPTH = 1 << S_LOG;
  localparam int T_DEPTH = 1 << T_LOG;
  localparam int CB_W    = 2 + 2 * VEF_BIT;

  localparam logic [S_LOG-1:0] S_PTR_ONE = {{(S_LOG-1){1'b0}}, 1'b1};
  localparam logic [S_LOG:0]   S_LEN_ONE = {{S_LOG{1'b0}}, 1'b1};
  localparam logic [T_LOG-1:0] T_PTR_ONE = {{(T_LOG-1){1'b0}}, 1'b1};
  localparam logic [T_LOG:0]   T_LEN_ONE = {{T_LOG{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [1:0]      s_mem  [S_DEPTH];
  logic [1:0]      t_mem  [T_DEPTH];
  logic [CB_W-1:0] colbuf [T_DEPTH];

  logic [S_LOG:0]   s_len;
  logic [T_LOG:0]   t_len;
  logic [S_LOG-1:0] s_ptr;
  logic [T_LOG-1:0] t_ptr;
  logic [T_LOG-1:0] wr_ptr;
  logic [S_LOG-1:0] pass;
  logic [T_LOG:0]   avail;
  logic             s_done;
  logic             ovf;

  logic            start_ok;
  logic            pass0;
  logic            s_last;
  logic            t_last;
  logic            wr_last;
  logic            data_valid;
  logic            s_pop;
  logic            t_pop;
  logic            t_consume;
  logic            wr_req;
  logic            wr_ok;
  logic            run_end;
  logic [CB_W-1:0] cb_rd;

  // A start only counts when both sequences are non-empty.
  assign start_ok   = (state == IDLE) && i_start && (i_s_len != '0) && (i_t_len != '0);
  assign pass0      = (pass == '0);
  assign s_last     = ({1'b0, s_ptr} == (s_len - S_LEN_ONE));
  assign t_last     = ({1'b0, t_ptr} == (t_len - T_LEN_ONE));
  assign wr_last    = ({1'b0, wr_ptr} == (t_len - T_LEN_ONE));
  // Later passes can only hand out column entries that have been written back.
  assign data_valid = (state == RUN) && (pass0 || (avail != '0));
  assign s_pop      = data_valid && i_update_s_w;
  assign t_pop      = data_valid && i_update_t_w;
  assign t_consume  = t_pop && !pass0;
  assign wr_req     = (state == RUN) && i_t_valid;
  // A full buffer still accepts a write if an entry is being consumed this cycle.
  assign wr_ok      = wr_req && !((avail == t_len) && !t_consume);
  assign run_end    = t_pop && t_last && (s_done || (s_pop && s_last));
  assign cb_rd      = colbuf[t_ptr];

  assign o_data_valid = data_valid;
  assign o_ovf        = ovf;
  assign o_s          = s_mem[s_ptr];
  assign o_s_last     = (state == RUN) && s_last;
  assign o_t_last     = (state == RUN) && t_last;
  assign o_t          = pass0 ? t_mem[t_ptr] : cb_rd[CB_W-1 -: 2];
  assign o_v          = ((state == RUN) && !pass0) ? cb_rd[2*VEF_BIT-1 -: VEF_BIT] : '0;
  assign o_f          = ((state == RUN) && !pass0) ? cb_rd[VEF_BIT-1:0] : '0;

  // State register; reset aborts any run straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic plus the busy/done status flags.
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: if (start_ok) state_next = RUN;
      RUN: begin
        o_busy = 1'b1;
        if (run_end) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run bookkeeping: lengths, read/write pointers, pass count, occupancy, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_len  <= '0;
      t_len  <= '0;
      s_ptr  <= '0;
      t_ptr  <= '0;
      wr_ptr <= '0;
      pass   <= '0;
      avail  <= '0;
      s_done <= 1'b0;
      ovf    <= 1'b0;
    end else if (start_ok) begin
      s_len  <= i_s_len;
      t_len  <= i_t_len;
      s_ptr  <= '0;
      t_ptr  <= '0;
      wr_ptr <= '0;
      pass   <= '0;
      avail  <= '0;
      s_done <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == RUN) begin
      if (s_pop && !s_last) s_ptr <= s_ptr + S_PTR_ONE;
      if (s_pop && s_last)  s_done <= 1'b1;
      if (t_pop) begin
        if (t_last) begin
          t_ptr <= '0;
          if (pass != '1) pass <= pass + S_PTR_ONE;
        end else begin
          t_ptr <= t_ptr + T_PTR_ONE;
        end
      end
      if (wr_ok)            wr_ptr <= wr_last ? '0 : (wr_ptr + T_PTR_ONE);
      if (wr_req && !wr_ok) ovf <= 1'b1;
      if (wr_ok && !t_consume)      avail <= avail + T_LEN_ONE;
      else if (!wr_ok && t_consume) avail <= avail - T_LEN_ONE;
    end
  end

  // Symbol memories are loaded by the host only while idle.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && i_s_wr) s_mem[i_s_addr] <= i_s_sym;
    if ((state == IDLE) && i_t_wr) t_mem[i_t_addr] <= i_t_sym;
  end

  // Column buffer captures the last PE's results for the next pass.
  always_ff @(posedge clk) begin
    if (wr_ok) colbuf[wr_ptr] <= {i_t, i_v, i_f};
  end

endmodule

// File: tb/tb_sw_seq_data_processor.sv
// Directed testbench for sw_seq_data_processor with a queue-based reference model.
module tb_sw_seq_data_processor;

  logic        clk;
  logic        rst_n;
  logic        i_s_wr;
  logic [7:0]  i_s_addr;
  logic [1:0]  i_s_sym;
  logic        i_t_wr;
  logic [9:0]  i_t_addr;
  logic [1:0]  i_t_sym;
  logic [8:0]  i_s_len;
  logic [10:0] i_t_len;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic        o_ovf;
  logic        o_data_valid;
  logic        i_update_s_w;
  logic [1:0]  o_s;
  logic        o_s_last;
  logic        i_update_t_w;
  logic [1:0]  o_t;
  logic [15:0] o_v;
  logic [15:0] o_f;
  logic        o_t_last;
  logic        i_t_valid;
  logic [1:0]  i_t;
  logic [15:0] i_v;
  logic [15:0] i_f;

  int n_checks = 0;
  int n_pass   = 0;

  sw_seq_data_processor #(.VEF_BIT(16), .S_LOG(8), .T_LOG(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_s_wr(i_s_wr), .i_s_addr(i_s_addr), .i_s_sym(i_s_sym),
    .i_t_wr(i_t_wr), .i_t_addr(i_t_addr), .i_t_sym(i_t_sym),
    .i_s_len(i_s_len), .i_t_len(i_t_len), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf), .o_data_valid(o_data_valid),
    .i_update_s_w(i_update_s_w), .o_s(o_s), .o_s_last(o_s_last),
    .i_update_t_w(i_update_t_w), .o_t(o_t), .o_v(o_v), .o_f(o_f), .o_t_last(o_t_last),
    .i_t_valid(i_t_valid), .i_t(i_t), .i_v(i_v), .i_f(i_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: symbol arrays plus a FIFO of written-back column entries.
  typedef struct packed {
    logic [1:0]  t;
    logic [15:0] v;
    logic [15:0] f;
  } entry_t;

  logic [1:0] s_m [256];
  logic [1:0] t_m [1024];
  entry_t     pend [$];
  entry_t     new_e;
  int         m_mode = 0;
  int         m_slen = 0;
  int         m_tlen = 0;
  int         m_si   = 0;
  int         m_ti   = 0;
  int         m_pass = 0;
  bit         m_sdone = 0;
  bit         m_ovf   = 0;
  bit         mv, msp, mtp, msl, mtl, mcons, mend;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; all inputs return to idle afterwards.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    i_s_wr = 0; i_t_wr = 0; i_start = 0;
    i_update_s_w = 0; i_update_t_w = 0; i_t_valid = 0;
    i_s_addr = '0; i_s_sym = '0; i_t_addr = '0; i_t_sym = '0;
    i_s_len = '0; i_t_len = '0; i_t = '0; i_v = '0; i_f = '0;
  endtask

  // Model update, evaluated on the same edge the DUT samples its inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_si = 0; m_ti = 0; m_pass = 0;
      m_sdone = 0; m_ovf = 0; m_slen = 0; m_tlen = 0;
      pend.delete();
    end else if (m_mode == 0) begin
      if (i_s_wr) s_m[i_s_addr] = i_s_sym;
      if (i_t_wr) t_m[i_t_addr] = i_t_sym;
      if (i_start && i_s_len != 0 && i_t_len != 0) begin
        m_slen = int'(i_s_len); m_tlen = int'(i_t_len);
        m_si = 0; m_ti = 0; m_pass = 0; m_sdone = 0; m_ovf = 0;
        pend.delete();
        m_mode = 1;
      end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else begin
      mv    = (m_pass == 0) || (pend.size() != 0);
      msp   = mv && i_update_s_w;
      mtp   = mv && i_update_t_w;
      msl   = (m_si == m_slen - 1);
      mtl   = (m_ti == m_tlen - 1);
      mcons = mtp && (m_pass > 0);
      mend  = mtp && mtl && (m_sdone || (msp && msl));
      new_e = '{t: i_t, v: i_v, f: i_f};
      if (i_t_valid && pend.size() == m_tlen && !mcons) m_ovf = 1;
      if (mcons) void'(pend.pop_front());
      if (i_t_valid && !(pend.size() == m_tlen)) pend.push_back(new_e);
      if (msp) begin
        if (msl) m_sdone = 1;
        else m_si++;
      end
      if (mtp) begin
        if (mtl) begin
          m_ti = 0;
          if (m_pass < 255) m_pass++;
        end else m_ti++;
      end
      if (mend) m_mode = 2;
    end
  end

  // Compare DUT against the model every cycle, on the falling edge.
  always @(negedge clk) begin
    checkOutput("busy", {31'b0, o_busy}, {31'b0, m_mode == 1});
    checkOutput("done", {31'b0, o_done}, {31'b0, m_mode == 2});
    checkOutput("ovf", {31'b0, o_ovf}, {31'b0, m_ovf});
    checkOutput("data_valid", {31'b0, o_data_valid},
                {31'b0, (m_mode == 1) && (m_pass == 0 || pend.size() != 0)});
    if ((m_mode == 1) && (m_pass == 0 || pend.size() != 0)) begin
      checkOutput("s", {30'b0, o_s}, {30'b0, s_m[m_si]});
      checkOutput("s_last", {31'b0, o_s_last}, {31'b0, m_si == m_slen - 1});
      checkOutput("t_last", {31'b0, o_t_last}, {31'b0, m_ti == m_tlen - 1});
      if (m_pass == 0) begin
        checkOutput("t", {30'b0, o_t}, {30'b0, t_m[m_ti]});
        checkOutput("v", {16'b0, o_v}, 32'd0);
        checkOutput("f", {16'b0, o_f}, 32'd0);
      end else begin
        checkOutput("t", {30'b0, o_t}, {30'b0, pend[0].t});
        checkOutput("v", {16'b0, o_v}, {16'b0, pend[0].v});
        checkOutput("f", {16'b0, o_f}, {16'b0, pend[0].f});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int wt [3] = '{3, 2, 1};
  int wv [3] = '{5, 7, 2};
  int wf [3] = '{0, 1, 0};

  initial begin
    rst_n = 0;
    i_s_wr = 0; i_t_wr = 0; i_start = 0;
    i_update_s_w = 0; i_update_t_w = 0; i_t_valid = 0;
    i_s_addr = '0; i_s_sym = '0; i_t_addr = '0; i_t_sym = '0;
    i_s_len = '0; i_t_len = '0; i_t = '0; i_v = '0; i_f = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("rst_done", {31'b0, o_done}, 32'd0);
    checkOutput("rst_ovf", {31'b0, o_ovf}, 32'd0);
    checkOutput("rst_valid", {31'b0, o_data_valid}, 32'd0);
    checkOutput("rst_tlast", {31'b0, o_t_last}, 32'd0);
    checkOutput("rst_v", {16'b0, o_v}, 32'd0);
    rst_n = 1;

    $display("[TB] load S=[0,1,2,3] T=[3,2,1]");
    for (int i = 0; i < 4; i++) begin
      i_s_wr = 1; i_s_addr = 8'(i); i_s_sym = 2'(i); applyStimulus();
    end
    for (int i = 0; i < 3; i++) begin
      i_t_wr = 1; i_t_addr = 10'(i); i_t_sym = 2'(3 - i); applyStimulus();
    end

    $display("[TB] run 1: pass 0 T pops");
    i_start = 1; i_s_len = 9'd4; i_t_len = 11'd3; applyStimulus();
    checkOutput("r1_busy", {31'b0, o_busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("r1_t", {30'b0, o_t}, 32'(3 - i));
      checkOutput("r1_tlast", {31'b0, o_t_last}, {31'b0, i == 2});
      i_update_t_w = 1; applyStimulus();
    end
    checkOutput("r1_valid_drop", {31'b0, o_data_valid}, 32'd0);

    $display("[TB] run 1: pass 1 writeback and readback");
    for (int i = 0; i < 3; i++) begin
      i_t_valid = 1; i_t = 2'(wt[i]); i_v = 16'(wv[i]); i_f = 16'(wf[i]); applyStimulus();
      checkOutput("r1_wb_valid", {31'b0, o_data_valid}, 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput("r1_rd_t", {30'b0, o_t}, 32'(wt[i]));
      checkOutput("r1_rd_v", {16'b0, o_v}, 32'(wv[i]));
      checkOutput("r1_rd_f", {16'b0, o_f}, 32'(wf[i]));
      i_update_t_w = 1; applyStimulus();
    end
    checkOutput("r1_old_v", {16'b0, o_v}, 32'd2);
    checkOutput("r1_tlast2", {31'b0, o_t_last}, 32'd1);
    i_update_t_w = 1; i_t_valid = 1; i_t = 2'd0; i_v = 16'd9; i_f = 16'd3; applyStimulus();
    checkOutput("r1_same_valid", {31'b0, o_data_valid}, 32'd1);
    checkOutput("r1_same_t", {30'b0, o_t}, 32'd0);
    checkOutput("r1_same_v", {16'b0, o_v}, 32'd9);
    checkOutput("r1_same_f", {16'b0, o_f}, 32'd3);
    i_update_t_w = 1; i_update_s_w = 1; applyStimulus();
    checkOutput("r1_empty", {31'b0, o_data_valid}, 32'd0);
    checkOutput("r1_s1", {30'b0, o_s}, 32'd1);
    i_update_s_w = 1; applyStimulus();
    checkOutput("r1_s_ignored", {30'b0, o_s}, 32'd1);
    i_t_valid = 1; i_t = 2'd2; i_v = 16'd4; i_f = 16'd4; applyStimulus();
    checkOutput("r1_wb2_v", {16'b0, o_v}, 32'd4);
    i_update_t_w = 1; applyStimulus();
    checkOutput("r1_pre_rst_t", {30'b0, o_t}, 32'd1);

    $display("[TB] reset mid-run at t_ptr=2");
    rst_n = 0;
    #1;
    checkOutput("mr_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("mr_valid", {31'b0, o_data_valid}, 32'd0);
    checkOutput("mr_s", {30'b0, o_s}, 32'd0);
    checkOutput("mr_t", {30'b0, o_t}, 32'd3);
    checkOutput("mr_tlast", {31'b0, o_t_last}, 32'd0);
    checkOutput("mr_v", {16'b0, o_v}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    i_start = 1; i_s_len = 9'd4; i_t_len = 11'd0; applyStimulus();
    checkOutput("zero_len_busy", {31'b0, o_busy}, 32'd0);

    $display("[TB] run 2: s_len=2, end via s_done");
    i_start = 1; i_s_len = 9'd2; i_t_len = 11'd3; applyStimulus();
    i_update_s_w = 1; i_s_wr = 1; i_s_addr = 8'd0; i_s_sym = 2'd3; applyStimulus();
    checkOutput("r2_slast", {31'b0, o_s_last}, 32'd1);
    i_update_s_w = 1; applyStimulus();
    checkOutput("r2_s_hold", {30'b0, o_s}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      i_update_t_w = 1; applyStimulus();
    end
    checkOutput("r2_done", {31'b0, o_done}, 32'd1);
    checkOutput("r2_busy", {31'b0, o_busy}, 32'd0);
    applyStimulus();
    checkOutput("r2_done_clr", {31'b0, o_done}, 32'd0);

    $display("[TB] run 3: simultaneous S-last and T-last pop");
    i_start = 1; i_s_len = 9'd1; i_t_len = 11'd1; applyStimulus();
    checkOutput("r3_s_no_wr", {30'b0, o_s}, 32'd0);
    checkOutput("r3_both_last", {30'b0, {o_s_last, o_t_last}}, 32'd3);
    i_update_s_w = 1; i_update_t_w = 1; applyStimulus();
    checkOutput("r3_done", {31'b0, o_done}, 32'd1);
    applyStimulus();

    $display("[TB] run 4: column buffer overflow");
    i_start = 1; i_s_len = 9'd4; i_t_len = 11'd3; applyStimulus();
    for (int i = 0; i < 4; i++) begin
      i_t_valid = 1; i_t = 2'(i); i_v = 16'(i + 10); i_f = 16'(i); applyStimulus();
      checkOutput("r4_ovf", {31'b0, o_ovf}, {31'b0, i == 3});
    end
    for (int i = 0; i < 4; i++) begin
      i_update_s_w = 1; applyStimulus();
    end
    for (int i = 0; i < 3; i++) begin
      i_update_t_w = 1; applyStimulus();
    end
    applyStimulus();
    checkOutput("r4_ovf_idle", {31'b0, o_ovf}, 32'd1);
    i_start = 1; i_s_len = 9'd1; i_t_len = 11'd1; applyStimulus();
    checkOutput("r5_ovf_clr", {31'b0, o_ovf}, 32'd0);
    i_update_s_w = 1; i_update_t_w = 1; applyStimulus();
    repeat (2) applyStimulus();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
